seq_event_monitor: RTL and testbench
====================================

SEQ_EVENT_MONITOR -- requirements
Module: seq_event_monitor

Interface
REQ-001 Parameters SHALL be: CNT_W, default 8, width of match counter; WINDOW, default 16, window length in cycles; THRESH, default 3, matches per window that raise alarm.
REQ-002 Port clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port z_in  input  1  match pulse from the upstream sequence detector; one match per high cycle.
REQ-005 Port clear  input  1  synchronous clear of count, alarm and gap.
REQ-006 Port count  output  CNT_W  total matches since reset/clear, saturating.
REQ-007 Port gap  output  8  cycles between the two most recent matches, saturating at 255.
REQ-008 Port alarm  output  1  sticky flag: THRESH matches seen within one window.
REQ-009 Port armed  output  1  high while a window is running (state ARMED).

Function
REQ-010 All outputs SHALL be registered; a z_in sampled at edge N SHALL be reflected on outputs after edge N (1-cycle latency).
REQ-011 count SHALL increment by 1 on every edge with z_in=1, saturating at 2^CNT_W-1 with no wrap.
REQ-012 An internal 8-bit gap timer SHALL increment every cycle, saturating at 255; on z_in=1, gap <= timer and timer <= 1.
REQ-013 The first match after reset/clear SHALL load gap=0 (no previous match); back-to-back matches SHALL give gap=1.
REQ-014 The FSM SHALL have states IDLE, ARMED, ALARM; armed=1 only in ARMED, alarm=1 only in ALARM.
REQ-015 IDLE: z_in=1 -> ARMED with win_cnt=0, hits=1; otherwise stay IDLE.
REQ-016 ARMED: win_cnt increments each cycle; z_in=1 increments hits.
REQ-017 ARMED: when hits would reach THRESH (including the current pulse) -> ALARM, with priority over window expiry.
REQ-018 ARMED: on the edge where win_cnt=WINDOW-1 and threshold is not reached -> IDLE with hits=0; if z_in=1 on that edge, stay ARMED with win_cnt=0, hits=1.
REQ-019 ALARM: sticky; z_in still updates count and gap but not hits; exits only on clear or reset.
REQ-020 clear=1 SHALL force IDLE, count=0, gap=0, hits=0, win_cnt=0, timer=0, first-match flag set, in any state.
REQ-021 clear and z_in high on the same edge: clear SHALL win and the pulse SHALL be discarded.
REQ-022 THRESH=1 SHALL take IDLE directly to ALARM on the first match.

Reset
REQ-023 reset=1 at an edge SHALL produce count=0, gap=0, alarm=0, armed=0, state IDLE, timer=0, first-match flag set.
REQ-024 reset SHALL override clear and z_in, including mid-window and in ALARM.

Verification
REQ-025 Reset then z_in pulses at cycles 2, 5, 9 (defaults) -> armed=1 after cycle 2, alarm=1 after cycle 9, count=3, gap=4.
REQ-026 Pulses at cycles 0 and 20 only -> armed returns to 0 after cycle 15; second pulse re-arms; count=2, gap=20, alarm=0.
REQ-027 Pulse at cycle 0, then pulse on expiry cycle 15 -> armed stays 1, new window starts with hits=1; pulse at 16 and 17 -> alarm=1.
REQ-028 z_in held high 300 cycles with CNT_W=8 -> count saturates at 255, gap=1, alarm=1 after 3rd cycle.
REQ-029 In ALARM assert clear together with z_in=1 -> next cycle count=0, gap=0, alarm=0, armed=0.
REQ-030 Assert reset mid-window with hits=2 -> all outputs zero next cycle; a following single pulse gives count=1, gap=0, armed=1.

Source files
------------

// File: rtl/seq_event_monitor.sv
// Counts match pulses from an upstream sequence detector, measures the spacing
// between matches and raises a sticky alarm when THRESH matches fall inside one window.
module seq_event_monitor #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16,
    parameter int THRESH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             z_in,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic [7:0]       gap,
    output logic             alarm,
    output logic             armed
);

    localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int HIT_W = (THRESH > 1) ? $clog2(THRESH + 1) : 1;
    localparam logic [HIT_W:0]   THR      = (HIT_W + 1)'(THRESH);
    // The window opens on the arming edge, so the last in-window edge sees WINDOW-2 here.
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 2);

    typedef enum logic [1:0] {IDLE, ARMED, ALARM} state_t;

    state_t           r_state;
    logic [7:0]       r_timer;
    logic             r_first;
    logic [WIN_W-1:0] r_win_cnt;
    logic [HIT_W-1:0] r_hits;

    logic [HIT_W:0]   w_hits_inc;
    logic             w_thresh;
    logic             w_expire;

    assign w_hits_inc = {1'b0, r_hits} + 1'b1;
    assign w_thresh   = z_in && (w_hits_inc >= THR);
    assign w_expire   = (r_win_cnt == WIN_LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_state   <= IDLE;
            count     <= '0;
            gap       <= '0;
            r_timer   <= '0;
            r_first   <= 1'b1;
            r_win_cnt <= '0;
            r_hits    <= '0;
            armed     <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            if (z_in) begin
                r_timer <= 8'd1;
                gap     <= r_first ? 8'd0 : r_timer;
                r_first <= 1'b0;
                if (count != '1)
                    count <= count + 1'b1;
            end else if (r_timer != '1) begin
                r_timer <= r_timer + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (z_in) begin
                        if (THRESH <= 1) begin
                            r_state <= ALARM;
                            alarm   <= 1'b1;
                        end else begin
                            r_state   <= ARMED;
                            armed     <= 1'b1;
                            r_win_cnt <= '0;
                            r_hits    <= HIT_W'(1);
                        end
                    end
                end
                ARMED: begin
                    if (w_thresh) begin
                        r_state <= ALARM;
                        armed   <= 1'b0;
                        alarm   <= 1'b1;
                    end else if (w_expire) begin
                        r_win_cnt <= '0;
                        if (z_in) begin
                            r_hits <= HIT_W'(1);
                        end else begin
                            r_state <= IDLE;
                            armed   <= 1'b0;
                            r_hits  <= '0;
                        end
                    end else begin
                        r_win_cnt <= r_win_cnt + 1'b1;
                        if (z_in)
                            r_hits <= w_hits_inc[HIT_W-1:0];
                    end
                end
                ALARM: begin
                    r_state <= ALARM;
                end
                default: begin
                    r_state <= IDLE;
                    armed   <= 1'b0;
                    alarm   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_event_monitor.sv
// Directed bench for seq_event_monitor: default instance plus a THRESH=1, CNT_W=2 instance.
module tb_seq_event_monitor;

    logic       clock;
    logic       reset;
    logic       z_in;
    logic       clear;
    logic [7:0] count;
    logic [7:0] gap;
    logic       alarm;
    logic       armed;
    logic [1:0] count2;
    logic [7:0] gap2;
    logic       alarm2;
    logic       armed2;

    int checks = 0;
    int fails  = 0;

    seq_event_monitor #(.CNT_W(8), .WINDOW(16), .THRESH(3)) u_dut (
        .clock(clock), .reset(reset), .z_in(z_in), .clear(clear),
        .count(count), .gap(gap), .alarm(alarm), .armed(armed)
    );

    seq_event_monitor #(.CNT_W(2), .WINDOW(16), .THRESH(1)) u_dut2 (
        .clock(clock), .reset(reset), .z_in(z_in), .clear(clear),
        .count(count2), .gap(gap2), .alarm(alarm2), .armed(armed2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step(input logic z, input logic c, input logic r);
        z_in  = z;
        clear = c;
        reset = r;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input int g, input int al, input int ar);
        check({tag, ".count"}, int'(count), c);
        check({tag, ".gap"},   int'(gap),   g);
        check({tag, ".alarm"}, int'(alarm), al);
        check({tag, ".armed"}, int'(armed), ar);
    endtask

    initial begin
        z_in  = 1'b0;
        clear = 1'b0;
        reset = 1'b1;

        // Reset state
        step(1'b1, 1'b1, 1'b1);
        check_all("reset", 0, 0, 0, 0);
        check("reset.alarm2", int'(alarm2), 0);

        // Pulses at cycles 2, 5, 9
        for (int i = 0; i <= 9; i++) begin
            step((i == 2) || (i == 5) || (i == 9), 1'b0, 1'b0);
            if (i == 1) check_all("s1.c1", 0, 0, 0, 0);
            if (i == 2) begin
                check_all("s1.c2", 1, 0, 0, 1);
                check("s1.c2.alarm2", int'(alarm2), 1);
                check("s1.c2.armed2", int'(armed2), 0);
            end
            if (i == 5) check_all("s1.c5", 2, 3, 0, 1);
            if (i == 9) check_all("s1.c9", 3, 4, 1, 0);
        end
        // ALARM is sticky; z still updates count and gap
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_all("s1.sticky", 4, 2, 1, 0);

        // Clear with z_in in ALARM: pulse discarded, next pulse is a first match
        step(1'b1, 1'b1, 1'b0);
        check_all("clr", 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_all("clr.next", 1, 0, 0, 1);

        // Pulses at 0 and 20: window expires after cycle 15
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= 20; i++) begin
            step((i == 0) || (i == 20), 1'b0, 1'b0);
            if (i == 14) check("s2.c14.armed", int'(armed), 1);
            if (i == 15) check("s2.c15.armed", int'(armed), 0);
            if (i == 20) check_all("s2.c20", 2, 20, 0, 1);
        end

        // Pulse on the expiry edge restarts the window with hits=1
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= 17; i++) begin
            step((i == 0) || (i >= 15), 1'b0, 1'b0);
            if (i == 15) check_all("s3.c15", 2, 15, 0, 1);
            if (i == 16) check_all("s3.c16", 3, 1, 0, 1);
            if (i == 17) check_all("s3.c17", 4, 1, 1, 0);
        end

        // Reset mid-window with hits=2 overrides z_in and clear
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_all("s4.pre", 2, 1, 0, 1);
        step(1'b1, 1'b1, 1'b1);
        check_all("s4.rst", 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        check_all("s4.p1", 1, 0, 0, 1);
        step(1'b1, 1'b0, 1'b0);
        check_all("s4.p2", 2, 1, 0, 1);

        // z_in held high for 300 cycles: saturation
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 0) check("s5.c0.count2", int'(count2), 1);
            if (i == 1) check_all("s5.c1", 2, 1, 0, 1);
            if (i == 2) check_all("s5.c2", 3, 1, 1, 0);
            if (i == 3) check("s5.c3.count2", int'(count2), 3);
            if (i == 253) check("s5.c253.count", int'(count), 254);
            if (i == 254) check("s5.c254.count", int'(count), 255);
        end
        check_all("s5.end", 255, 1, 1, 0);
        check("s5.end.count2", int'(count2), 3);
        check("s5.end.alarm2", int'(alarm2), 1);

        // Reset in ALARM, then gap timer saturation at 255
        step(1'b0, 1'b1, 1'b1);
        check_all("s6.rst", 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_all("s6.gapsat", 2, 255, 0, 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
